i2s_tx_multi: RTL and testbench

Parametrised I2S/TDM serial audio transmitter for the synthesiser output path. It generates mclk, sck and lrck from the system clk, accepts one packed multi-channel frame per handshake, and serialises it MSB-first on sdout. It generalises the fixed stereo 16-bit output stage in sample width, slot width, channel count and clock ratios, and adds input double-buffering and underrun reporting.

---
 rtl/i2s_tx_multi.sv | 134 +++++++++++++
 tb/tb_i2s_tx_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_multi.sv
// rtl/i2s_tx_multi.sv - parametrised I2S/TDM transmitter with double-buffered input and underrun flag
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (MSB coincides with the lrck edge).
module i2s_tx_multi #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int MCLK_DIV = 8,
  parameter int SCK_DIV  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         mclk,
  output logic                         sck,
  output logic                         lrck,
  output logic                         sdout,
  output logic                         frame_start,
  output logic                         underrun
);
  localparam int FRAME_BITS = CHANNELS * SLOT_W;
  localparam int DATA_W     = CHANNELS * SAMPLE_W;
  localparam int MW = $clog2(MCLK_DIV);
  localparam int SW = $clog2(SCK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV / 2 - 1);
  localparam logic [SW-1:0] SCK_LAST  = SW'(SCK_DIV - 1);
  localparam logic [SW-1:0] SCK_HALF  = SW'(SCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] BIT_HALF  = BW'(FRAME_BITS / 2);
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic [SW-1:0] SCK_PRE   = SW'(SCK_DIV - 2);
`endif

  // Stream order: ch0 slot first, each slot MSB-first with zero padding in the LSBs.
  function automatic logic [FRAME_BITS-1:0] to_stream(input logic [DATA_W-1:0] d);
    logic [FRAME_BITS-1:0] v;
    logic [SAMPLE_W-1:0]   smp;
    v = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      smp = SAMPLE_W'(d >> (s * SAMPLE_W));
      v   = (v << SLOT_W) | FRAME_BITS'(SLOT_W'(smp) << (SLOT_W - SAMPLE_W));
    end
    return v;
  endfunction

  logic [MW-1:0]         mclk_cnt_q, mclk_cnt_d;
  logic [SW-1:0]         sck_cnt_q, sck_cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, load_vec;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic hold_full_q, hold_full_d, in_ready_q, in_ready_d;
  logic mclk_q, mclk_d, sck_q, sck_d, lrck_q, lrck_d, sdout_q, sdout_d;
  logic frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic fall, boundary, accept, load;

  always_comb begin
    fall     = (sck_cnt_q == SCK_LAST);
    boundary = fall && (bit_q == BIT_LAST);
    accept   = in_valid && in_ready_q;

    mclk_cnt_d = (mclk_cnt_q == MCLK_LAST) ? '0 : mclk_cnt_q + MW'(1);
    mclk_d     = (mclk_cnt_q == MCLK_LAST) ? ~mclk_q : mclk_q;
    sck_cnt_d  = fall ? '0 : sck_cnt_q + SW'(1);
    sck_d      = (sck_cnt_d >= SCK_HALF);
    bit_d      = bit_q;
    if (fall) bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
    lrck_d     = (bit_d >= BIT_HALF);

`ifdef I2S_LEFT_JUSTIFIED_EN
    // Load one clk early; a same-cycle accept into an empty holding register is forwarded.
    load     = (sck_cnt_q == SCK_PRE) && (bit_q == BIT_LAST);
    load_vec = (hold_full_q || accept) ? to_stream(hold_full_q ? hold_q : in_data) : '0;
`else
    load     = boundary;
    load_vec = hold_full_q ? to_stream(hold_q) : '0;
`endif

    sdout_d = fall ? shift_q[FRAME_BITS-1] : sdout_q;
    shift_d = shift_q;
    if (fall) shift_d = shift_q << 1;
    if (load) shift_d = load_vec;

    hold_d      = accept ? in_data : hold_q;
    hold_full_d = hold_full_q;
    if (boundary) hold_full_d = 1'b0;
    if (accept)   hold_full_d = 1'b1;
    in_ready_d  = !hold_full_q && !accept;

    frame_start_d = boundary;
    underrun_d    = boundary && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt_q    <= '0;
      sck_cnt_q     <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      mclk_q        <= 1'b0;
      sck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      sdout_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      mclk_cnt_q    <= mclk_cnt_d;
      sck_cnt_q     <= sck_cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      in_ready_q    <= in_ready_d;
      mclk_q        <= mclk_d;
      sck_q         <= sck_d;
      lrck_q        <= lrck_d;
      sdout_q       <= sdout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mclk        = mclk_q;
  assign sck         = sck_q;
  assign lrck        = lrck_q;
  assign sdout       = sdout_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx_multi.sv
// tb/tb_i2s_tx_multi.sv - scoreboard bench for i2s_tx_multi, stereo default plus a 4-slot TDM instance
// Honours I2S_LEFT_JUSTIFIED_EN when defined.
module tb_i2s_tx_multi;
  localparam int SAMPLE_W = 16, SLOT_W = 32, CHANNELS = 2, MCLK_DIV = 8, SCK_DIV = 32;
  localparam int FB   = CHANNELS * SLOT_W;
  localparam int FCLK = FB * SCK_DIV;
  localparam int DW   = CHANNELS * SAMPLE_W;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, mclk, sck, lrck, sdout, frame_start, underrun;
  logic [95:0] t_data = '0;
  logic t_valid = 1'b0;
  logic t_ready, t_mclk, t_sck, t_lrck, t_sdout, t_fs, t_ur;

  always #5 clk = ~clk;

  i2s_tx_multi #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .CHANNELS(CHANNELS),
                 .MCLK_DIV(MCLK_DIV), .SCK_DIV(SCK_DIV)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mclk(mclk), .sck(sck), .lrck(lrck), .sdout(sdout),
    .frame_start(frame_start), .underrun(underrun));

  i2s_tx_multi #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .MCLK_DIV(2), .SCK_DIV(4)) tdm (
    .clk(clk), .rst(rst), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
    .mclk(t_mclk), .sck(t_sck), .lrck(t_lrck), .sdout(t_sdout),
    .frame_start(t_fs), .underrun(t_ur));

  int n_assert = 0, n_fail = 0;
  int n = 0, acc_cnt = 0;
  int first_rise, first_fall, first_lr, first_fs;
  logic sbq[$];
  logic [DW-1:0] pend[$];
  bit prev_full, exp_ready, exp_ur, sck_prev, t_sck_prev, tdm_on, last_acc, ur0;
  logic [63:0]  cap;
  logic [127:0] t_cap;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b at n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream of one frame: slot s = p / SLOT_W, bit k = p % SLOT_W.
  task automatic push_frame(input logic [DW-1:0] data);
    logic [DW-1:0] tmp;
    for (int p = 0; p < FB; p++) begin
      tmp = data >> ((p / SLOT_W) * SAMPLE_W + SAMPLE_W - 1 - (p % SLOT_W));
      sbq.push_back(((p % SLOT_W) < SAMPLE_W) ? tmp[0] : 1'b0);
    end
  endtask

  task automatic tick();
    bit acc, bnd;
    logic [DW-1:0] d;
    logic e;
    acc = in_valid && in_ready;
    d   = in_data;
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (rst) begin
      checkv("reset_outputs", 128'({in_ready, mclk, sck, lrck, sdout, frame_start, underrun,
                                   t_ready, t_mclk, t_sck, t_lrck, t_sdout, t_fs, t_ur}), 128'(0));
      return;
    end
    n++;
    last_acc = acc;
    bnd = (n % FCLK == 0);
    exp_ur = 1'b0;
    if (bnd) begin
      if (pend.size() == 0) begin
        exp_ur = 1'b1;
        push_frame('0);
      end else begin
        push_frame(pend.pop_front());
      end
    end
    exp_ready = !prev_full && !acc;
    if (acc) pend.push_back(d);
    prev_full = (pend.size() != 0);

    check1("sck", sck, (n % SCK_DIV) >= SCK_DIV / 2);
    check1("lrck", lrck, ((n / SCK_DIV) % FB) >= FB / 2);
    check1("mclk", mclk, ((n / (MCLK_DIV / 2)) % 2) == 1);
    check1("frame_start", frame_start, bnd);
    check1("underrun", underrun, exp_ur);
    check1("in_ready", in_ready, exp_ready);
    if (sck && !sck_prev) begin
      if (sbq.size() == 0) checki("scoreboard_depth", sbq.size(), 1);
      else begin
        e = sbq.pop_front();
        check1("sdout", sdout, e);
      end
      if (n / FCLK == 1) cap = {cap[62:0], sdout};
    end
    if (first_rise < 0 && sck) first_rise = n;
    if (first_fall < 0 && first_rise >= 0 && !sck) first_fall = n;
    if (first_lr < 0 && lrck) first_lr = n;
    if (first_fs < 0 && frame_start) first_fs = n;
    if (underrun && n < FCLK) ur0 = 1'b1;
    sck_prev = sck;

    if (tdm_on && t_sck && !t_sck_prev) begin
      check1("tdm_lrck", t_lrck, ((n / 4) % 128) >= 64);
      if (n / 512 == 1) t_cap = {t_cap[126:0], t_sdout};
    end
    t_sck_prev = t_sck;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    n = 0;
    sbq.delete();
    pend.delete();
    prev_full = 1'b0;
    sck_prev = 1'b0;
    t_sck_prev = 1'b0;
    if (!LJ) sbq.push_back(1'b0);
    push_frame('0);
  endtask

  // Reset release, load {ch1=0001, ch0=A5F0} into frame 1, run up to the frame-2 boundary.
  task automatic scenario1(input bit with_tdm);
    release_rst();
    tdm_on = with_tdm;
    first_rise = -1; first_fall = -1; first_lr = -1; first_fs = -1;
    ur0 = 1'b0; cap = '0; t_cap = '0;
    tick();
    check1("ready_after_release", in_ready, 1'b1);
    in_data = {16'h0001, 16'hA5F0};
    in_valid = 1'b1;
    if (with_tdm) begin
      t_data = '0;
      t_data[71:48] = 24'h800000;
      t_valid = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    t_valid = 1'b0;
    check1("ready_drop_after_accept", in_ready, 1'b0);
    while (n < 2 * FCLK) tick();
    checki("first_sck_rise", first_rise, 16);
    checki("first_sck_fall", first_fall, 32);
    checki("first_lrck_rise", first_lr, 1024);
    checki("first_frame_start", first_fs, 2048);
    check1("no_underrun_frame0", ur0, 1'b0);
    checkv("frame1_sdout_by_bit", 128'(cap),
           128'(LJ ? 64'hA5F0_0000_0001_0000 : 64'h52F8_0000_0000_8000));
    if (with_tdm) checkv("tdm_ch2_msb_position", t_cap, LJ ? (128'd1 << 63) : (128'd1 << 62));
    tdm_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) tick();
    scenario1(1'b1);

    // Nothing was offered during frame 1, so the frame-2 boundary is an underrun.
    check1("underrun_after_skip", underrun, 1'b1);
    check1("frame_start_with_underrun", frame_start, 1'b1);

    in_valid = 1'b1;
    in_data = $urandom;
    acc_cnt = 0;
    while (n < 6 * FCLK) begin
      tick();
      if (last_acc) begin
        acc_cnt++;
        in_data = $urandom;
      end
    end
    in_valid = 1'b0;
    checki("accepts_over_4_frames", acc_cnt, 4);

    while (n < 6 * FCLK + 20 * SCK_DIV + 5) tick();
    rst = 1'b1;
    repeat (4) tick();
    scenario1(1'b0);
    repeat (100) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
